// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice:
// FSM state encodings and the default payload width.
package uart_pkg;

  // Arbiter FSM states; START and WAIT differ in one bit so WAIT is reached
  // from START by setting the upper bit only.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_WAIT  = 2'b11
  } arb_state_e;

  // Default number of bits carried per byte transfer.
  localparam int unsigned UART_PAYLOAD_BITS = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: starting at the pointer and wrapping past the top
// index, finds the first valid requester. Purely combinational.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned Param_NumReq  = 4,
  parameter int unsigned Param_IdxBits = $clog2(Param_NumReq)
) (
  input  logic [Param_NumReq-1:0]  valid_i,
  input  logic [Param_IdxBits-1:0] ptr_i,
  output logic [Param_NumReq-1:0]  grant_o,
  output logic [Param_IdxBits-1:0] idx_o,
  output logic                     any_o
);

  logic [Param_IdxBits-1:0] sel;
  int unsigned              pos;

  // Scan positions ptr, ptr+1, ... (mod NumReq) and latch the first valid one
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    sel     = '0;
    pos     = 0;
    for (int unsigned k = 0; k < Param_NumReq; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= Param_NumReq) begin
        pos = pos - Param_NumReq;
      end
      sel = Param_IdxBits'(pos);
      if (!any_o && valid_i[sel]) begin
        any_o        = 1'b1;
        idx_o        = sel;
        grant_o[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several byte requesters share one UART
// transmitter. A grant captures the winner's byte, fires a one-cycle start
// pulse, then waits for the transmitter's done pulse under a watchdog.
// Optional grant locking is enabled by defining UART_TX_ARB_LOCK_EN; the
// default build is pure round-robin and leaves IO_ReqLock_I unused.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned Param_NumReq        = 4,
  parameter int unsigned Param_PayloadBits   = UART_PAYLOAD_BITS,
  parameter int unsigned Param_TimeoutCycles = 4096
) (
  input  logic                                      IO_Clk_I,
  input  logic                                      IO_Rst_I,
  input  logic [Param_NumReq-1:0]                   IO_ReqValid_I,
  input  logic [Param_NumReq*Param_PayloadBits-1:0] IO_ReqData_I,
  input  logic [Param_NumReq-1:0]                   IO_ReqLock_I,
  output logic [Param_NumReq-1:0]                   IO_ReqReady_O,
  output logic                                      IO_TxStart_O,
  output logic [Param_PayloadBits-1:0]              IO_TxData_O,
  input  logic                                      IO_TxBusy_I,
  input  logic                                      IO_TxDone_I,
  output logic [$clog2(Param_NumReq)-1:0]           IO_GrantId_O,
  output logic                                      IO_Timeout_O
);

  localparam int unsigned IdxBits  = $clog2(Param_NumReq);
  localparam int unsigned WdogBits = $clog2(Param_TimeoutCycles) + 1;
  localparam logic [WdogBits-1:0] WdogLast = WdogBits'(Param_TimeoutCycles - 1);
  localparam logic [IdxBits-1:0]  LastIdx  = IdxBits'(Param_NumReq - 1);

  arb_state_e                 state_q, state_d;
  logic [IdxBits-1:0]         ptr_q, ptr_d;
  logic [IdxBits-1:0]         grantId_q, grantId_d;
  logic [Param_PayloadBits-1:0] txData_q, txData_d;
  logic [WdogBits-1:0]        wdog_q, wdog_d;
  logic                       timeout_q, timeout_d;

  logic [Param_NumReq-1:0]    pickGrant;
  logic [IdxBits-1:0]         pickIdx;
  logic                       pickAny;
  logic                       accept;
  logic [Param_PayloadBits-1:0] selData;
  logic [IdxBits-1:0]         ptrAdvance;
  logic [IdxBits-1:0]         leavePtr;
  logic                       lockHold;
  logic [WdogBits-1:0]        wdogNext;

  uart_rr_pick #(
    .Param_NumReq  (Param_NumReq),
    .Param_IdxBits (IdxBits)
  ) u_pick (
    .valid_i (IO_ReqValid_I),
    .ptr_i   (ptr_q),
    .grant_o (pickGrant),
    .idx_o   (pickIdx),
    .any_o   (pickAny)
  );

  // A byte is accepted only from IDLE while the transmitter is free
  assign accept        = (state_q == ST_IDLE) && !IO_TxBusy_I && pickAny;
  assign IO_ReqReady_O = accept ? pickGrant : '0;

`ifdef UART_TX_ARB_LOCK_EN
  // A locked requester keeps the pointer on itself so it wins again
  assign lockHold = IO_ReqLock_I[grantId_q];
`else
  logic unusedLock;
  assign lockHold   = 1'b0;
  assign unusedLock = ^IO_ReqLock_I;
`endif

  assign ptrAdvance = (grantId_q == LastIdx) ? '0 : grantId_q + IdxBits'(1);
  assign leavePtr   = lockHold ? grantId_q : ptrAdvance;

  // Mux the winning requester's byte out of the packed data bus
  always_comb begin
    selData = '0;
    for (int unsigned i = 0; i < Param_NumReq; i++) begin
      if (pickGrant[i]) begin
        selData = IO_ReqData_I[i*Param_PayloadBits +: Param_PayloadBits];
      end
    end
  end

  // Next-state logic: grant in IDLE, one start cycle, then watch for done
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grantId_d = grantId_q;
    txData_d  = txData_q;
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
    wdogNext  = wdog_q + WdogBits'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          grantId_d = pickIdx;
          txData_d  = selData;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_d = wdogNext;
        if (IO_TxDone_I) begin
          state_d = ST_IDLE;
          ptr_d   = leavePtr;
        end else if (wdogNext == WdogLast) begin
          state_d   = ST_IDLE;
          ptr_d     = leavePtr;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight
  always_ff @(posedge IO_Clk_I or negedge IO_Rst_I) begin
    if (!IO_Rst_I) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grantId_q <= '0;
      txData_q  <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grantId_q <= grantId_d;
      txData_q  <= txData_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign IO_TxStart_O = (state_q == ST_START);
  assign IO_TxData_O  = txData_q;
  assign IO_GrantId_O = grantId_q;
  assign IO_Timeout_O = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed byte transfers with a
// scoreboard of expected grants, watchdog, locking and reset-abort cases.
module tb_uart_tx_arbiter;

  localparam int NReq = 4;
  localparam int W    = 8;
  localparam int T    = 16;

`ifdef UART_TX_ARB_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  typedef struct {
    int         id;
    logic [7:0] data;
  } expTxn_t;

  logic              clk = 1'b0;
  logic              rstN;
  logic [NReq-1:0]   reqValid;
  logic [NReq*W-1:0] reqData;
  logic [NReq-1:0]   reqLock;
  logic [NReq-1:0]   reqReady;
  logic              txStart;
  logic [W-1:0]      txData;
  logic              txBusy;
  logic              txDone;
  logic [1:0]        grantId;
  logic              timeoutPulse;

  int      vectorCount = 0;
  int      missCount   = 0;
  int      modelPtr    = 0;
  expTxn_t sbQ[$];

  uart_tx_arbiter #(
    .Param_NumReq        (NReq),
    .Param_PayloadBits   (W),
    .Param_TimeoutCycles (T)
  ) dut (
    .IO_Clk_I      (clk),
    .IO_Rst_I      (rstN),
    .IO_ReqValid_I (reqValid),
    .IO_ReqData_I  (reqData),
    .IO_ReqLock_I  (reqLock),
    .IO_ReqReady_O (reqReady),
    .IO_TxStart_O  (txStart),
    .IO_TxData_O   (txData),
    .IO_TxBusy_I   (txBusy),
    .IO_TxDone_I   (txDone),
    .IO_GrantId_O  (grantId),
    .IO_Timeout_O  (timeoutPulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic int pickModel(input logic [3:0] v, input int ptr);
    for (int k = 0; k < NReq; k++) begin
      int i;
      i = (ptr + k) % NReq;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] lk, input logic [31:0] d);
    reqValid = v;
    reqLock  = lk;
    reqData  = d;
  endtask

  // One complete transfer: request, accept, start, then done/timeout
  task automatic runByte(input string tag, input logic [3:0] v, input logic [3:0] lk,
                         input int doneAfter, input logic [31:0] d);
    int      expId;
    expTxn_t e;
    e.id   = 0;
    e.data = '0;
    @(negedge clk);
    applyStimulus(v, lk, d);
    expId = pickModel(v, modelPtr);
    sbQ.push_back('{id: expId, data: d[expId*8 +: 8]});
    #1;
    checkOutput({tag, ":ready"}, 32'(reqReady), 32'(1) << expId);
    @(negedge clk);
    reqValid = '0;
    checkOutput({tag, ":txstart"}, 32'(txStart), 32'd1);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput({tag, ":txdata"}, 32'(txData), 32'(e.data));
      checkOutput({tag, ":grantid"}, 32'(grantId), 32'(e.id));
    end else begin
      vectorCount++;
      missCount++;
      $display("[TB] FAIL %s:scoreboard observed=empty expected=entry", tag);
    end
    for (int k = 1; k <= T + 4; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput({tag, ":startpulse"}, 32'(txStart), 32'd0);
      checkOutput({tag, ":timeout"}, 32'(timeoutPulse), (doneAfter < 0 && k == T) ? 32'd1 : 32'd0);
      if (doneAfter < 0 && k == T) begin
        @(negedge clk);
        checkOutput({tag, ":timeout_clear"}, 32'(timeoutPulse), 32'd0);
        break;
      end
      if (k == doneAfter) begin
        txDone = 1'b1;
        @(negedge clk);
        txDone = 1'b0;
        checkOutput({tag, ":no_timeout"}, 32'(timeoutPulse), 32'd0);
        checkOutput({tag, ":grant_hold"}, 32'(grantId), 32'(e.id));
        break;
      end
    end
    if (LockEn && lk[expId]) modelPtr = expId;
    else modelPtr = (expId + 1) % NReq;
  endtask

  initial begin
    int preId;
    rstN = 1'b0;
    txBusy = 1'b0;
    txDone = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("rst:txstart", 32'(txStart), 32'd0);
    checkOutput("rst:timeout", 32'(timeoutPulse), 32'd0);
    checkOutput("rst:grantid", 32'(grantId), 32'd0);
    checkOutput("rst:txdata", 32'(txData), 32'd0);
    checkOutput("rst:ready", 32'(reqReady), 32'd0);
    rstN = 1'b1;

    // All requesters valid: strict rotation from index 0
    for (int n = 0; n < 5; n++) runByte("rr", 4'b1111, 4'b0000, 5, $urandom());

    // Busy transmitter blocks any grant
    @(negedge clk);
    applyStimulus(4'b0001, 4'b0000, 32'h0);
    txBusy = 1'b1;
    #1;
    checkOutput("busy:ready", 32'(reqReady), 32'd0);
    @(negedge clk);
    checkOutput("busy:ready2", 32'(reqReady), 32'd0);
    checkOutput("busy:txstart", 32'(txStart), 32'd0);
    reqValid = '0;
    txBusy = 1'b0;

    // Single requester with known byte
    runByte("single", 4'b0001, 4'b0000, 10, 32'h1234_56A5);

    // Done pulse while idle is ignored
    @(negedge clk);
    txDone = 1'b1;
    @(negedge clk);
    txDone = 1'b0;
    checkOutput("idledone:txstart", 32'(txStart), 32'd0);
    checkOutput("idledone:timeout", 32'(timeoutPulse), 32'd0);

    // Watchdog expiry, then the next requester is served
    runByte("wdog", 4'b0010, 4'b0000, -1, $urandom());
    runByte("afterwdog", 4'b0011, 4'b0000, 5, $urandom());

    // Done on the last watchdog cycle wins over timeout
    runByte("coincide", 4'b0100, 4'b0000, T - 1, $urandom());
    runByte("park", 4'b1000, 4'b0000, 5, $urandom());

    // Lock on requester 2 competing with requester 3
    runByte("lock1", 4'b1100, 4'b0100, 5, $urandom());
    runByte("lock2", 4'b1100, 4'b0100, 5, $urandom());
    runByte("lock3", 4'b1100, 4'b0000, 5, $urandom());
    runByte("lock4", 4'b1100, 4'b0000, 5, $urandom());

    // Reset in the middle of WAIT aborts the transfer
    @(negedge clk);
    applyStimulus(4'b0010, 4'b0000, $urandom());
    preId = pickModel(4'b0010, modelPtr);
    #1;
    checkOutput("abort:ready", 32'(reqReady), 32'(1) << preId);
    @(negedge clk);
    reqValid = '0;
    checkOutput("abort:txstart", 32'(txStart), 32'd1);
    repeat (3) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("abort:rst_txstart", 32'(txStart), 32'd0);
    checkOutput("abort:rst_timeout", 32'(timeoutPulse), 32'd0);
    checkOutput("abort:rst_grantid", 32'(grantId), 32'd0);
    checkOutput("abort:rst_txdata", 32'(txData), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    modelPtr = 0;
    for (int n = 0; n < T + 2; n++) begin
      @(negedge clk);
      checkOutput("abort:no_stale_start", 32'(txStart), 32'd0);
      checkOutput("abort:no_stale_timeout", 32'(timeoutPulse), 32'd0);
    end
    runByte("postrst", 4'b1000, 4'b0000, 5, $urandom());

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter Param_NumReq, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter Param_PayloadBits, default 8, bits per byte.
REQ-003 SHALL have parameter Param_TimeoutCycles, default 4096, maximum clocks to wait for transmitter done.
REQ-004 SHALL have port IO_Clk_I  in  1  clock, rising edge.
REQ-005 SHALL have port IO_Rst_I  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port IO_ReqValid_I  in  Param_NumReq  per-requester byte valid.
REQ-007 SHALL have port IO_ReqData_I  in  Param_NumReq*Param_PayloadBits  requester i data at bits [i*W +: W].
REQ-008 SHALL have port IO_ReqLock_I  in  Param_NumReq  per-requester grant hold; ignored without macro.
REQ-009 SHALL have port IO_ReqReady_O  out  Param_NumReq  one-hot accept pulse.
REQ-010 SHALL have port IO_TxStart_O  out  1  one-cycle transmitter start pulse.
REQ-011 SHALL have port IO_TxData_O  out  Param_PayloadBits  byte to transmitter, held from accept to IDLE.
REQ-012 SHALL have port IO_TxBusy_I  in  1  transmitter busy.
REQ-013 SHALL have port IO_TxDone_I  in  1  transmitter byte-complete pulse.
REQ-014 SHALL have port IO_GrantId_O  out  $clog2(Param_NumReq)  index of current/last grant.
REQ-015 SHALL have port IO_Timeout_O  out  1  one-cycle pulse on watchdog abort.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT; reset state IDLE.
REQ-017 In IDLE with IO_TxBusy_I=0 and any valid: grant first valid index at or after round-robin pointer (wrapping past Param_NumReq-1 to 0), pulse its IO_ReqReady_O, capture data and id, next state START.
REQ-018 In IDLE with IO_TxBusy_I=1 or no valid: all ready bits 0, stay IDLE.
REQ-019 IO_ReqReady_O SHALL be combinational from state, valid, busy and pointer; at most one bit high per cycle.
REQ-020 START SHALL assert IO_TxStart_O exactly one cycle, clear the watchdog counter, then go to WAIT.
REQ-021 WAIT SHALL increment watchdog each cycle; IO_TxDone_I=1 -> IDLE; counter reaching Param_TimeoutCycles-1 without done -> pulse IO_Timeout_O next cycle, go IDLE.
REQ-022 IO_TxDone_I and timeout in the same cycle: done wins, no timeout pulse.
REQ-023 IO_TxDone_I in IDLE or START SHALL be ignored.
REQ-024 On leaving WAIT the pointer SHALL become (granted id + 1) mod Param_NumReq.
REQ-025 Accept-to-start latency SHALL be 1 cycle; minimum byte-to-next-accept interval 3 cycles after done.
REQ-026 Watchdog width SHALL be $clog2(Param_TimeoutCycles)+1 bits; no wrap.

Reset
REQ-027 Reset SHALL force state IDLE, pointer 0, IO_TxData_O 0, IO_GrantId_O 0, IO_TxStart_O 0, IO_Timeout_O 0, watchdog 0.
REQ-028 Reset asserted in START or WAIT SHALL abort with no start/timeout pulse; after release the arbiter serves from index 0.

Configuration
REQ-029 Macro UART_TX_ARB_LOCK_EN SHALL enable grant locking.
REQ-030 With UART_TX_ARB_LOCK_EN: if IO_ReqLock_I[granted id] is high when leaving WAIT, pointer SHALL stay at granted id, so that requester wins the next arbitration if valid.
REQ-031 Without UART_TX_ARB_LOCK_EN: IO_ReqLock_I SHALL be unused; pure round-robin per REQ-024.

Structure
REQ-032 Shared package uart_pkg SHALL hold the FSM state encodings (IDLE=2'b00, START=2'b01, WAIT=2'b11) and the default payload width.
REQ-033 Sub-module uart_rr_pick SHALL compute the rotated first-valid one-hot and index from valid vector and pointer; purely combinational.

Verification
REQ-034 Valid=4'b0001, data0=8'hA5, busy=0 -> ready=4'b0001 one cycle, TxStart next cycle with TxData=8'hA5; done after 10 cycles -> IDLE, GrantId=0.
REQ-035 All four valid continuously, done 5 cycles after each start -> grants in order 0,1,2,3,0.
REQ-036 Param_TimeoutCycles=16, no done -> IO_Timeout_O pulses exactly once 16 cycles after TxStart, arbiter serves next requester.
REQ-037 Done and timeout coincide on last watchdog cycle -> no timeout pulse, normal return to IDLE.
REQ-038 With UART_TX_ARB_LOCK_EN, requester 2 lock=1 and valid with requester 3 valid -> three consecutive grants to 2; lock drops -> next grant 3. Without macro -> alternating 2,3.
REQ-039 Reset pulsed in WAIT, then valid=4'b1000 -> no stale TxStart; grant 3 after release with pointer starting at 0.
